// File: rtl/core_inst_seq.sv
`default_nettype none
// ============================================================================
// Module   : core_inst_seq
// Brief    : Instruction sequencer for a Q/K attention core. It streams host
//            Q and K vectors into the core memories, loads K, runs execute,
//            moves the psums and reads the psum rows back as results.
// Revision : 1.0 - initial release
// ============================================================================
module core_inst_seq #(
  parameter int bw          = 8,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int bw_psum     = 20,
  parameter int total_cycle = 8,
  parameter int gap         = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [pr*bw-1:0]       in_data,
  output logic [pr*bw-1:0]       mem_in,
  output logic [16:0]            inst,
  input  logic [bw_psum*col-1:0] pmem_out,
  output logic                   result_valid,
  output logic [3:0]             result_addr,
  output logic [bw_psum*col-1:0] result_data,
  output logic                   busy,
  output logic                   done
);

  // Instruction word bit positions
  localparam int B_OFIFO_RD = 16;
  localparam int B_EXECUTE  = 7;
  localparam int B_LOAD     = 6;
  localparam int B_QMEM_RD  = 5;
  localparam int B_QMEM_WR  = 4;
  localparam int B_KMEM_RD  = 3;
  localparam int B_KMEM_WR  = 2;
  localparam int B_PMEM_RD  = 1;
  localparam int B_PMEM_WR  = 0;

  // The gap counter only needs to reach gap-1
  localparam int GW = (gap > 1) ? $clog2(gap) : 1;

  localparam logic [3:0]    TC_LAST  = 4'(total_cycle - 1);
  localparam logic [3:0]    COL_LAST = 4'(col - 1);
  localparam logic [3:0]    KL_LAST  = 4'(col);
  localparam logic [GW-1:0] GAP_LAST = GW'(gap - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_QWR   = 4'd1,
    S_KWR   = 4'd2,
    S_KLOAD = 4'd3,
    S_KTAIL = 4'd4,
    S_GAP1  = 4'd5,
    S_EXEC  = 4'd6,
    S_GAP2  = 4'd7,
    S_MOVE  = 4'd8,
    S_PRD   = 4'd9,
    S_DONE  = 4'd10
  } state_t;

  state_t          state, state_n;
  logic [3:0]      step, step_n;
  logic [GW-1:0]   gcnt, gcnt_n;
  logic            phase, phase_n;
  logic [16:0]     inst_n;
  logic            done_n;
  logic            rd_second, rd_second_n;
  logic [3:0]      rd_addr, rd_addr_n;
  logic            ready;
  logic            hs;

  assign ready    = (state == S_QWR) || (state == S_KWR);
  assign in_ready = ready;
  assign hs       = in_valid & ready;
  assign busy     = (state != S_IDLE);

  // Next-state, counter and instruction decode; every output defaults to idle
  always_comb begin
    state_n     = state;
    step_n      = step;
    gcnt_n      = gcnt;
    phase_n     = phase;
    inst_n      = '0;
    done_n      = 1'b0;
    rd_second_n = (state == S_PRD) && phase;
    rd_addr_n   = step;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_QWR;
          step_n  = '0;
        end
      end
      S_QWR: begin
        if (hs) begin
          inst_n[B_QMEM_WR] = 1'b1;
          inst_n[15:12]     = step;
          if (step == TC_LAST) begin
            state_n = S_KWR;
            step_n  = '0;
          end else begin
            step_n = step + 4'd1;
          end
        end
      end
      S_KWR: begin
        if (hs) begin
          inst_n[B_KMEM_WR] = 1'b1;
          inst_n[15:12]     = step;
          if (step == COL_LAST) begin
            state_n = S_KLOAD;
            step_n  = '0;
          end else begin
            step_n = step + 4'd1;
          end
        end
      end
      S_KLOAD: begin
        // kmem read runs one step behind load so the address lags by one
        inst_n[B_LOAD]    = 1'b1;
        inst_n[B_KMEM_RD] = (step != 4'd0);
        inst_n[15:12]     = (step <= 4'd1) ? 4'd0 : (step - 4'd1);
        if (step == KL_LAST) begin
          state_n = S_KTAIL;
          step_n  = '0;
        end else begin
          step_n = step + 4'd1;
        end
      end
      S_KTAIL: begin
        inst_n[B_LOAD] = 1'b1;
        state_n        = S_GAP1;
        gcnt_n         = '0;
      end
      S_GAP1: begin
        if (gcnt == GAP_LAST) begin
          state_n = S_EXEC;
          step_n  = '0;
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      S_EXEC: begin
        inst_n[B_EXECUTE] = 1'b1;
        inst_n[B_QMEM_RD] = 1'b1;
        inst_n[15:12]     = step;
        if (step == TC_LAST) begin
          state_n = S_GAP2;
          gcnt_n  = '0;
        end else begin
          step_n = step + 4'd1;
        end
      end
      S_GAP2: begin
        if (gcnt == GAP_LAST) begin
          state_n = S_MOVE;
          step_n  = '0;
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      S_MOVE: begin
        inst_n[B_OFIFO_RD] = 1'b1;
        inst_n[B_PMEM_WR]  = 1'b1;
        inst_n[11:8]       = step;
        if (step == TC_LAST) begin
          state_n = S_PRD;
          step_n  = '0;
          phase_n = 1'b0;
        end else begin
          step_n = step + 4'd1;
        end
      end
      S_PRD: begin
        // Each address is held for two read cycles; data is taken after the second
        inst_n[B_PMEM_RD] = 1'b1;
        inst_n[11:8]      = step;
        phase_n           = ~phase;
        if (phase) begin
          if (step == TC_LAST) begin
            state_n = S_DONE;
            step_n  = '0;
          end else begin
            step_n = step + 4'd1;
          end
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, counters and registered core-facing outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      step      <= '0;
      gcnt      <= '0;
      phase     <= 1'b0;
      inst      <= '0;
      mem_in    <= '0;
      done      <= 1'b0;
      rd_second <= 1'b0;
      rd_addr   <= '0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      gcnt      <= gcnt_n;
      phase     <= phase_n;
      inst      <= inst_n;
      done      <= done_n;
      rd_second <= rd_second_n;
      rd_addr   <= rd_addr_n;
      if (hs) begin
        mem_in <= in_data;
      end
    end
  end

  // Capture the psum row at the end of the second read cycle of each address
  always_ff @(posedge clk) begin
    if (reset) begin
      result_valid <= 1'b0;
      result_addr  <= '0;
      result_data  <= '0;
    end else begin
      result_valid <= rd_second;
      if (rd_second) begin
        result_addr <= rd_addr;
        result_data <= pmem_out;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_inst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_inst_seq
// Brief    : Self-checking bench for core_inst_seq (vector table, inst trace
//            scoreboard, psum result scoreboard, reset/start corner cases).
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_inst_seq;

  localparam int BW  = 8;
  localparam int PR  = 8;
  localparam int COL = 8;
  localparam int BWP = 20;
  localparam int TC  = 8;
  localparam int GAP = 10;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic                 in_valid;
  logic                 in_ready;
  logic [PR*BW-1:0]     in_data;
  logic [PR*BW-1:0]     mem_in;
  logic [16:0]          inst;
  logic [BWP*COL-1:0]   pmem_out;
  logic                 result_valid;
  logic [3:0]           result_addr;
  logic [BWP*COL-1:0]   result_data;
  logic                 busy;
  logic                 done;

  core_inst_seq #(
    .bw(BW), .pr(PR), .col(COL), .bw_psum(BWP), .total_cycle(TC), .gap(GAP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .mem_in(mem_in), .inst(inst),
    .pmem_out(pmem_out), .result_valid(result_valid), .result_addr(result_addr),
    .result_data(result_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Core psum memory model: every element of row a reads back as a
  assign pmem_out = {COL{BWP'(inst[11:8])}};

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        start;
    logic        in_valid;
    logic [63:0] data;
    logic [16:0] exp_inst;
    logic        exp_ready;
    logic [63:0] exp_mem;
  } vec_t;

  typedef struct {
    logic [16:0] inst;
    logic        busy;
    logic        done;
  } trace_t;

  typedef struct {
    logic [3:0]   addr;
    logic [159:0] data;
  } res_t;

  vec_t   vtab[18];
  trace_t exp_q[$];
  res_t   res_q[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic trace_t tr(input logic [16:0] i, input logic b, input logic d);
    trace_t t;
    t.inst = i;
    t.busy = b;
    t.done = d;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    trace_t t;
    res_t   r;
    int     pulses;
    logic [63:0] dv;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;

    // QWR with in_valid low every other cycle, then the first K handshake
    vtab[0].start = 1'b1; vtab[0].in_valid = 1'b0; vtab[0].data = 64'hDEAD_BEEF;
    vtab[0].exp_inst = '0; vtab[0].exp_ready = 1'b1; vtab[0].exp_mem = '0;
    for (int n = 0; n < 8; n++) begin
      dv = {8{8'(8'h11 * (n + 1))}};
      vtab[1+2*n].start = 1'b0; vtab[1+2*n].in_valid = 1'b1; vtab[1+2*n].data = dv;
      vtab[1+2*n].exp_inst = 17'h00010 | 17'(n << 12);
      vtab[1+2*n].exp_ready = 1'b1; vtab[1+2*n].exp_mem = dv;
      vtab[2+2*n].start = 1'b0; vtab[2+2*n].in_valid = 1'b0; vtab[2+2*n].data = ~dv;
      vtab[2+2*n].exp_inst = '0; vtab[2+2*n].exp_ready = 1'b1; vtab[2+2*n].exp_mem = dv;
    end
    vtab[17].start = 1'b0; vtab[17].in_valid = 1'b1; vtab[17].data = 64'hCAFE_F00D_1234_5678;
    vtab[17].exp_inst = 17'h00004; vtab[17].exp_ready = 1'b1;
    vtab[17].exp_mem = 64'hCAFE_F00D_1234_5678;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    chk("rst_inst", inst, 0);
    chk("rst_mem_in", mem_in, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_addr", result_addr, 0);
    chk("rst_result_data", result_data, 0);

    // Table-driven stall sequence
    for (int i = 0; i < 18; i++) begin
      start    = vtab[i].start;
      in_valid = vtab[i].in_valid;
      in_data  = vtab[i].data;
      tick();
      chk($sformatf("vec%0d_inst", i), inst, vtab[i].exp_inst);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vtab[i].exp_ready);
      chk($sformatf("vec%0d_mem_in", i), mem_in, vtab[i].exp_mem);
    end

    // Abort in KWR
    start = 1'b0; in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("kwr_abort_busy", busy, 0);
    chk("kwr_abort_inst", inst, 0);
    chk("kwr_abort_mem_in", mem_in, 0);
    chk("kwr_abort_in_ready", in_ready, 0);

    // Expected inst trace of a full run without host stalls
    exp_q.delete();
    exp_q.push_back(tr(17'h0, 1'b1, 1'b0));
    for (int n = 0; n < TC; n++) exp_q.push_back(tr(17'h00010 | 17'(n << 12), 1'b1, 1'b0));
    for (int n = 0; n < COL; n++) exp_q.push_back(tr(17'h00004 | 17'(n << 12), 1'b1, 1'b0));
    for (int k = 0; k <= COL; k++)
      exp_q.push_back(tr(17'h00040 | ((k >= 1) ? 17'h8 : 17'h0) | ((k <= 1) ? 17'h0 : 17'((k - 1) << 12)),
                         1'b1, 1'b0));
    exp_q.push_back(tr(17'h00040, 1'b1, 1'b0));
    for (int g = 0; g < GAP; g++) exp_q.push_back(tr(17'h0, 1'b1, 1'b0));
    for (int n = 0; n < TC; n++) exp_q.push_back(tr(17'h000A0 | 17'(n << 12), 1'b1, 1'b0));
    for (int g = 0; g < GAP; g++) exp_q.push_back(tr(17'h0, 1'b1, 1'b0));
    for (int n = 0; n < TC; n++) exp_q.push_back(tr(17'h10001 | 17'(n << 8), 1'b1, 1'b0));
    for (int a = 0; a < TC; a++) begin
      exp_q.push_back(tr(17'h00002 | 17'(a << 8), 1'b1, 1'b0));
      exp_q.push_back(tr(17'h00002 | 17'(a << 8), 1'b1, 1'b0));
    end
    exp_q.push_back(tr(17'h0, 1'b0, 1'b1));
    exp_q.push_back(tr(17'h0, 1'b0, 1'b0));

    res_q.delete();
    for (int a = 0; a < TC; a++) begin
      r.addr = 4'(a);
      r.data = '0;
      for (int e = 0; e < COL; e++) r.data[e*BWP +: BWP] = BWP'(a);
      res_q.push_back(r);
    end

    // Full run; stray start pulses in KWR (cycle 12) and MOVE (cycle 56)
    pulses   = 0;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    for (int i = 0; i < 81; i++) begin
      tick();
      start   = (i == 12) || (i == 56);
      in_data = {$urandom, $urandom};
      if (exp_q.size() == 0) begin
        chk("trace_underflow", 1, 0);
      end else begin
        t = exp_q.pop_front();
        chk($sformatf("run_c%0d_inst_busy_done", i), {inst, busy, done}, {t.inst, t.busy, t.done});
      end
      if (result_valid) begin
        pulses++;
        if (res_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          r = res_q.pop_front();
          chk($sformatf("res_addr_c%0d", i), result_addr, r.addr);
          chk($sformatf("res_data_c%0d", i), result_data, r.data);
        end
      end
    end
    start = 1'b0;
    chk("result_pulses", pulses, TC);
    chk("result_pending", res_q.size(), 0);

    // Reset during EXEC step 3, together with start
    start    = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      start = 1'b0;
    end
    chk("exec_step2_inst", inst, 17'h020A0);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("exec_abort_inst", inst, 0);
    chk("exec_abort_busy", busy, 0);
    chk("exec_abort_in_ready", in_ready, 0);
    chk("exec_abort_mem_in", mem_in, 0);

    // Fresh run restarts at QWR index 0
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_first_inst", inst, 0);
    in_valid = 1'b1;
    in_data  = 64'h0123_4567_89AB_CDEF;
    tick();
    chk("restart_q0_inst", inst, 17'h00010);
    chk("restart_q0_mem_in", mem_in, 64'h0123_4567_89AB_CDEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
